mon_rule_ctrl: RTL and testbench
================================

# mon_rule_ctrl

Sequencer that owns the monitoring TCAM rule-management port of the monitoring output-port-lookup core. It accepts single read, single write and whole-table fill commands from the host register block. It drives the TCAM `rd`/`wr` request/acknowledge handshakes one transaction at a time, guarded by a timeout, and returns one response per command. It sits between the AXI-Lite register decoder and the core's `mon_rd_*`/`mon_wr_*` ports.

## Interface
Parameters:
- `TUPLE_WIDTH`, 104, rule and mask width.
- `MON_LUT_DEPTH_BITS`, 4, TCAM address width; table holds 2^MON_LUT_DEPTH_BITS entries.
- `TIMEOUT_CYCLES`, 64, maximum cycles a TCAM request may stay pending. Legal range 2..65535.

Ports:
- `clk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  block idle and able to accept a command.
- `cmd_op`  in  2  operation: 00 read, 01 write, 10 fill, 11 illegal.
- `cmd_addr`  in  MON_LUT_DEPTH_BITS  entry address (ignored for fill).
- `cmd_rule`  in  TUPLE_WIDTH  rule for write/fill.
- `cmd_mask`  in  TUPLE_WIDTH  mask for write/fill.
- `rsp_valid`  out  1  response available; held until accepted.
- `rsp_ready`  in  1  response consumed.
- `rsp_status`  out  2  response status: 0 OK, 1 TIMEOUT, 2 VERIFY_MISMATCH, 3 BAD_OP.
- `rsp_addr`  out  MON_LUT_DEPTH_BITS  address of the last entry touched.
- `rsp_rule`, `rsp_mask`  out  TUPLE_WIDTH each  readback data.
- `busy`  out  1  high whenever not in IDLE.
- `err_cnt`  out  16  saturating count of non-OK responses.
- TCAM read side: `mon_rd_addr` (out, MON_LUT_DEPTH_BITS), `mon_rd_req` (out, 1), `mon_rd_rule` (in, TUPLE_WIDTH), `mon_rd_rulemask` (in, TUPLE_WIDTH), `mon_rd_ack` (in, 1).
- TCAM write side: `mon_wr_addr` (out, MON_LUT_DEPTH_BITS), `mon_wr_req` (out, 1), `mon_wr_rule` (out, TUPLE_WIDTH), `mon_wr_rulemask` (out, TUPLE_WIDTH), `mon_wr_ack` (in, 1).

## Operation
- All outputs are registered.
- Reset value of every output is 0, with one exception: `cmd_ready` resets to 0 and rises on the first cycle after reset deasserts.
- States:
  - IDLE: `cmd_ready`=1. On `cmd_valid`, the command is latched.
    - op 00 goes to RD_WAIT.
    - op 01 goes to WR_WAIT.
    - op 10 goes to FILL_WR with address 0.
    - op 11 goes to RESP with status BAD_OP.
  - RD_WAIT: `mon_rd_req`=1 with the latched address.
    - On `mon_rd_ack`, capture `mon_rd_rule`/`mon_rd_rulemask` into `rsp_rule`/`rsp_mask` and go to RESP with status OK.
  - WR_WAIT: `mon_wr_req`=1 with the latched address, rule and mask.
    - On `mon_wr_ack`, go to RESP with status OK (or to VERIFY when the macro is enabled).
  - FILL_WR: same as WR_WAIT, but on ack the address increments and FILL_WR continues.
    - On ack at the last address (all ones), go to RESP with status OK and `rsp_addr` set to the last address.
  - VERIFY: present only with the macro. Described under Configuration.
  - RESP: `rsp_valid`=1. On `rsp_ready`, return to IDLE.
- Request/acknowledge rules:
  - `*_req` is a level held until the ack or until timeout.
  - Ack is a single-cycle pulse; the ack cycle is the last cycle `*_req` is high.
  - Reads and writes are never requested at the same time.
- Timeout:
  - A 16-bit counter clears when a request is issued and increments each cycle the request is pending.
  - If the counter reaches TIMEOUT_CYCLES-1 without an ack, drop `*_req`, go to RESP with status TIMEOUT, and set `rsp_addr` to the failing address.
  - A timeout aborts a fill at that address; remaining entries are not written.
- An ack arriving while no request of that type is pending (IDLE, RESP, or the other type) is ignored.
- `err_cnt` increments by 1 on entry to RESP with a non-OK status and saturates at 0xFFFF. It is cleared only by reset.
- Reset mid-operation: state returns to IDLE, requests drop on the reset edge, and any pending response is discarded.

## Timing
- Command accepted at edge N: `*_req` is high from cycle N+1.
- Ack sampled at edge M: `*_req` is low and `rsp_valid` is high at M+1.
- Best-case read or write latency from accept to `rsp_valid` is 2 cycles when ack returns one cycle after req.
- Fill: each entry costs 1 cycle plus the ack latency. Between entries, `mon_wr_req` stays high and `mon_wr_addr` updates in the cycle after the ack.
- The `rsp_*` fields are stable while `rsp_valid`=1 and `rsp_ready`=0.
- Commands are never accepted while `rsp_valid`=1.

## Configuration
- `MON_RULE_READBACK_VERIFY_EN` defined:
  - After every write ack (single write or each fill entry), the block enters VERIFY.
  - VERIFY issues `mon_rd_req` to the same address and compares the returned rule and mask with the written values.
  - Mismatch: go to RESP with status VERIFY_MISMATCH and `rsp_addr` set to the entry; a fill aborts.
  - Match: continue as without the macro.
  - The verify read has its own timeout.
- `MON_RULE_READBACK_VERIFY_EN` undefined: the VERIFY state and comparator are absent, and status 2 is never produced.

## Test plan
- Write addr 5 with rule 0x0A0B, mask all-ones, TCAM acking 3 cycles later -> one `mon_wr_req` pulse train at addr 5; `rsp_status`=0, `rsp_addr`=5; `err_cnt`=0.
- Read addr 5, TCAM returns 0x0A0B/0xFF..F on ack -> `rsp_rule`=0x0A0B, `rsp_mask`=all-ones, status 0, latency 2 cycles with immediate ack.
- Fill with TCAM acking every request after 1 cycle -> 16 writes at addresses 0..15 in order; single response with `rsp_addr`=15, status 0.
- Read with ack never returned, TIMEOUT_CYCLES=64 -> `mon_rd_req` drops after 64 cycles; status 1; `err_cnt`=1; a stray ack injected afterwards causes no change.
- `cmd_op`=11, then `reset` asserted during a fill at addr 7 -> BAD_OP response with `err_cnt`=1; after reset, no request is active, `busy`=0 and `err_cnt`=0.
- With `MON_RULE_READBACK_VERIFY_EN`, TCAM returns a corrupted bit on the readback of addr 3 during a fill -> status 2, `rsp_addr`=3, no write issued to addr 4.

Source files
------------

// File: rtl/mon_rule_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mon_rule_ctrl_if
//  Description : Host-side command/response bus of the monitoring TCAM rule
//                sequencer.
//                Command channel : cmd_valid/cmd_ready handshake carrying
//                                  cmd_op, cmd_addr, cmd_rule, cmd_mask.
//                Response channel: rsp_valid/rsp_ready handshake carrying
//                                  rsp_status, rsp_addr, rsp_rule, rsp_mask.
//                master : host register block (issues commands).
//                slave  : mon_rule_ctrl (executes commands).
//  Revision    : 1.0 - initial release
// ============================================================================
interface mon_rule_ctrl_if #(
    parameter int TUPLE_WIDTH        = 104,
    parameter int MON_LUT_DEPTH_BITS = 4
);
    logic                          cmd_valid;
    logic                          cmd_ready;
    logic [1:0]                    cmd_op;
    logic [MON_LUT_DEPTH_BITS-1:0] cmd_addr;
    logic [TUPLE_WIDTH-1:0]        cmd_rule;
    logic [TUPLE_WIDTH-1:0]        cmd_mask;

    logic                          rsp_valid;
    logic                          rsp_ready;
    logic [1:0]                    rsp_status;
    logic [MON_LUT_DEPTH_BITS-1:0] rsp_addr;
    logic [TUPLE_WIDTH-1:0]        rsp_rule;
    logic [TUPLE_WIDTH-1:0]        rsp_mask;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_rule, cmd_mask, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_status, rsp_addr, rsp_rule, rsp_mask
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_rule, cmd_mask, rsp_ready,
        output cmd_ready, rsp_valid, rsp_status, rsp_addr, rsp_rule, rsp_mask
    );
endinterface
`default_nettype wire

// File: rtl/mon_rule_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mon_rule_ctrl
//  Description : Sequencer for the monitoring TCAM rule-management port.
//                Executes single read, single write and whole-table fill
//                commands one TCAM transaction at a time, each request
//                guarded by a timeout, and returns one response per command.
//  Ports       : clk, reset        - clock, synchronous active-high reset
//                bus (slave)       - host command/response channel
//                busy              - high whenever not idle
//                err_cnt           - saturating count of non-OK responses
//                mon_rd_*          - TCAM read request/ack port
//                mon_wr_*          - TCAM write request/ack port
//  Options     : MON_RULE_READBACK_VERIFY_EN - when defined, every write is
//                followed by a readback compare (VERIFY state).
//  Revision    : 1.0 - initial release
// ============================================================================
module mon_rule_ctrl #(
    parameter int TUPLE_WIDTH        = 104,
    parameter int MON_LUT_DEPTH_BITS = 4,
    parameter int TIMEOUT_CYCLES     = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    mon_rule_ctrl_if.slave                bus,
    output logic                          busy,
    output logic [15:0]                   err_cnt,
    output logic [MON_LUT_DEPTH_BITS-1:0] mon_rd_addr,
    output logic                          mon_rd_req,
    input  logic [TUPLE_WIDTH-1:0]        mon_rd_rule,
    input  logic [TUPLE_WIDTH-1:0]        mon_rd_rulemask,
    input  logic                          mon_rd_ack,
    output logic [MON_LUT_DEPTH_BITS-1:0] mon_wr_addr,
    output logic                          mon_wr_req,
    output logic [TUPLE_WIDTH-1:0]        mon_wr_rule,
    output logic [TUPLE_WIDTH-1:0]        mon_wr_rulemask,
    input  logic                          mon_wr_ack
);

    localparam logic [1:0] c_OP_READ  = 2'b00;
    localparam logic [1:0] c_OP_WRITE = 2'b01;
    localparam logic [1:0] c_OP_FILL  = 2'b10;

    localparam logic [1:0] c_ST_OK      = 2'd0;
    localparam logic [1:0] c_ST_TIMEOUT = 2'd1;
`ifdef MON_RULE_READBACK_VERIFY_EN
    localparam logic [1:0] c_ST_VERIFY  = 2'd2;
`endif
    localparam logic [1:0] c_ST_BAD_OP  = 2'd3;

    localparam logic [15:0]                   c_TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [MON_LUT_DEPTH_BITS-1:0] c_ADDR_LAST = '1;
    localparam logic [MON_LUT_DEPTH_BITS-1:0] c_ADDR_ONE  = MON_LUT_DEPTH_BITS'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_WAIT = 3'd1,
        S_WR_WAIT = 3'd2,
        S_FILL_WR = 3'd3,
        S_RESP    = 3'd4
`ifdef MON_RULE_READBACK_VERIFY_EN
        , S_VERIFY = 3'd5
`endif
    } state_t;

    state_t                          r_state;
    logic                            r_fill;
    logic [15:0]                     r_tmo_cnt;
    logic                            r_cmd_ready;
    logic                            r_rsp_valid;
    logic [1:0]                      r_rsp_status;
    logic [MON_LUT_DEPTH_BITS-1:0]   r_rsp_addr;
    logic [TUPLE_WIDTH-1:0]          r_rsp_rule;
    logic [TUPLE_WIDTH-1:0]          r_rsp_mask;
    logic                            r_busy;
    logic [15:0]                     r_err_cnt;
    logic [MON_LUT_DEPTH_BITS-1:0]   r_rd_addr;
    logic                            r_rd_req;
    logic [MON_LUT_DEPTH_BITS-1:0]   r_wr_addr;
    logic                            r_wr_req;
    logic [TUPLE_WIDTH-1:0]          r_wr_rule;
    logic [TUPLE_WIDTH-1:0]          r_wr_mask;

    logic        w_tmo_hit;
    logic [15:0] w_err_cnt_inc;

    // Pending request has used up its cycle budget (ack on the same edge wins).
    assign w_tmo_hit     = (r_tmo_cnt == c_TMO_LAST);
    assign w_err_cnt_inc = (r_err_cnt == 16'hFFFF) ? r_err_cnt : r_err_cnt + 16'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_fill       <= 1'b0;
            r_tmo_cnt    <= '0;
            r_cmd_ready  <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_status <= '0;
            r_rsp_addr   <= '0;
            r_rsp_rule   <= '0;
            r_rsp_mask   <= '0;
            r_busy       <= 1'b0;
            r_err_cnt    <= '0;
            r_rd_addr    <= '0;
            r_rd_req     <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_req     <= 1'b0;
            r_wr_rule    <= '0;
            r_wr_mask    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // cmd_ready comes up one cycle after reset releases.
                    r_cmd_ready <= 1'b1;
                    if (r_cmd_ready && bus.cmd_valid) begin
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_tmo_cnt   <= '0;
                        r_fill      <= 1'b0;
                        case (bus.cmd_op)
                            c_OP_READ: begin
                                r_rd_addr <= bus.cmd_addr;
                                r_rd_req  <= 1'b1;
                                r_state   <= S_RD_WAIT;
                            end
                            c_OP_WRITE: begin
                                r_wr_addr <= bus.cmd_addr;
                                r_wr_rule <= bus.cmd_rule;
                                r_wr_mask <= bus.cmd_mask;
                                r_wr_req  <= 1'b1;
                                r_state   <= S_WR_WAIT;
                            end
                            c_OP_FILL: begin
                                r_wr_addr <= '0;
                                r_wr_rule <= bus.cmd_rule;
                                r_wr_mask <= bus.cmd_mask;
                                r_wr_req  <= 1'b1;
                                r_fill    <= 1'b1;
                                r_state   <= S_FILL_WR;
                            end
                            default: begin
                                r_rsp_addr   <= bus.cmd_addr;
                                r_rsp_status <= c_ST_BAD_OP;
                                r_rsp_valid  <= 1'b1;
                                r_err_cnt    <= w_err_cnt_inc;
                                r_state      <= S_RESP;
                            end
                        endcase
                    end
                end

                S_RD_WAIT: begin
                    if (mon_rd_ack) begin
                        r_rd_req     <= 1'b0;
                        r_rsp_rule   <= mon_rd_rule;
                        r_rsp_mask   <= mon_rd_rulemask;
                        r_rsp_addr   <= r_rd_addr;
                        r_rsp_status <= c_ST_OK;
                        r_rsp_valid  <= 1'b1;
                        r_state      <= S_RESP;
                    end else if (w_tmo_hit) begin
                        r_rd_req     <= 1'b0;
                        r_rsp_addr   <= r_rd_addr;
                        r_rsp_status <= c_ST_TIMEOUT;
                        r_rsp_valid  <= 1'b1;
                        r_err_cnt    <= w_err_cnt_inc;
                        r_state      <= S_RESP;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 16'd1;
                    end
                end

                // Single write and fill share the write handshake; r_fill
                // decides whether an ack advances to the next entry.
                S_WR_WAIT, S_FILL_WR: begin
                    if (mon_wr_ack) begin
`ifdef MON_RULE_READBACK_VERIFY_EN
                        r_wr_req  <= 1'b0;
                        r_rd_addr <= r_wr_addr;
                        r_rd_req  <= 1'b1;
                        r_tmo_cnt <= '0;
                        r_state   <= S_VERIFY;
`else
                        if (r_fill && (r_wr_addr != c_ADDR_LAST)) begin
                            // mon_wr_req stays high; only the address moves.
                            r_wr_addr <= r_wr_addr + c_ADDR_ONE;
                            r_tmo_cnt <= '0;
                        end else begin
                            r_wr_req     <= 1'b0;
                            r_rsp_addr   <= r_wr_addr;
                            r_rsp_status <= c_ST_OK;
                            r_rsp_valid  <= 1'b1;
                            r_state      <= S_RESP;
                        end
`endif
                    end else if (w_tmo_hit) begin
                        // Aborts a fill at this entry.
                        r_wr_req     <= 1'b0;
                        r_rsp_addr   <= r_wr_addr;
                        r_rsp_status <= c_ST_TIMEOUT;
                        r_rsp_valid  <= 1'b1;
                        r_err_cnt    <= w_err_cnt_inc;
                        r_state      <= S_RESP;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 16'd1;
                    end
                end

`ifdef MON_RULE_READBACK_VERIFY_EN
                S_VERIFY: begin
                    if (mon_rd_ack) begin
                        r_rd_req <= 1'b0;
                        if ((mon_rd_rule != r_wr_rule) || (mon_rd_rulemask != r_wr_mask)) begin
                            r_rsp_addr   <= r_wr_addr;
                            r_rsp_status <= c_ST_VERIFY;
                            r_rsp_valid  <= 1'b1;
                            r_err_cnt    <= w_err_cnt_inc;
                            r_state      <= S_RESP;
                        end else if (r_fill && (r_wr_addr != c_ADDR_LAST)) begin
                            r_wr_addr <= r_wr_addr + c_ADDR_ONE;
                            r_wr_req  <= 1'b1;
                            r_tmo_cnt <= '0;
                            r_state   <= S_FILL_WR;
                        end else begin
                            r_rsp_addr   <= r_wr_addr;
                            r_rsp_status <= c_ST_OK;
                            r_rsp_valid  <= 1'b1;
                            r_state      <= S_RESP;
                        end
                    end else if (w_tmo_hit) begin
                        r_rd_req     <= 1'b0;
                        r_rsp_addr   <= r_wr_addr;
                        r_rsp_status <= c_ST_TIMEOUT;
                        r_rsp_valid  <= 1'b1;
                        r_err_cnt    <= w_err_cnt_inc;
                        r_state      <= S_RESP;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 16'd1;
                    end
                end
`endif

                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready   = r_cmd_ready;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_status  = r_rsp_status;
    assign bus.rsp_addr    = r_rsp_addr;
    assign bus.rsp_rule    = r_rsp_rule;
    assign bus.rsp_mask    = r_rsp_mask;
    assign busy            = r_busy;
    assign err_cnt         = r_err_cnt;
    assign mon_rd_addr     = r_rd_addr;
    assign mon_rd_req      = r_rd_req;
    assign mon_wr_addr     = r_wr_addr;
    assign mon_wr_req      = r_wr_req;
    assign mon_wr_rule     = r_wr_rule;
    assign mon_wr_rulemask = r_wr_mask;

endmodule
`default_nettype wire

// File: tb/tb_mon_rule_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mon_rule_ctrl
//  Description : Directed self-checking bench for mon_rule_ctrl. A small
//                behavioural TCAM answers requests after a programmable
//                number of request-high cycles (0 = never) and logs writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mon_rule_ctrl;

    localparam int TW = 104;
    localparam int DB = 4;
    localparam logic [TW-1:0] ONES = '1;

`ifdef MON_RULE_READBACK_VERIFY_EN
    localparam int WR_LAT_EXP   = 5;
    localparam int FILL_LAT_EXP = 49;
`else
    localparam int WR_LAT_EXP   = 4;
    localparam int FILL_LAT_EXP = 33;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          busy;
    logic [15:0]   err_cnt;
    logic [DB-1:0] mon_rd_addr;
    logic          mon_rd_req;
    logic [TW-1:0] mon_rd_rule = '0;
    logic [TW-1:0] mon_rd_rulemask = '0;
    logic          mon_rd_ack = 1'b0;
    logic [DB-1:0] mon_wr_addr;
    logic          mon_wr_req;
    logic [TW-1:0] mon_wr_rule;
    logic [TW-1:0] mon_wr_rulemask;
    logic          mon_wr_ack = 1'b0;

    mon_rule_ctrl_if #(.TUPLE_WIDTH(TW), .MON_LUT_DEPTH_BITS(DB)) bus ();

    mon_rule_ctrl #(.TUPLE_WIDTH(TW), .MON_LUT_DEPTH_BITS(DB), .TIMEOUT_CYCLES(64)) dut (
        .clk             (clk),
        .reset           (reset),
        .bus             (bus),
        .busy            (busy),
        .err_cnt         (err_cnt),
        .mon_rd_addr     (mon_rd_addr),
        .mon_rd_req      (mon_rd_req),
        .mon_rd_rule     (mon_rd_rule),
        .mon_rd_rulemask (mon_rd_rulemask),
        .mon_rd_ack      (mon_rd_ack),
        .mon_wr_addr     (mon_wr_addr),
        .mon_wr_req      (mon_wr_req),
        .mon_wr_rule     (mon_wr_rule),
        .mon_wr_rulemask (mon_wr_rulemask),
        .mon_wr_ack      (mon_wr_ack)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural TCAM ----------------
    int            wr_lat = 3;
    int            rd_lat = 1;
    int            corrupt_addr = -1;
    logic          stray_rd = 1'b0;
    logic          stray_wr = 1'b0;
    int            wr_cnt = 0;
    int            rd_cnt = 0;
    int            wr_log[$];
    logic [TW-1:0] mem_rule [16] = '{default: '0};
    logic [TW-1:0] mem_mask [16] = '{default: '0};

    always @(negedge clk) begin
        mon_wr_ack = 1'b0;
        mon_rd_ack = 1'b0;
        if (mon_wr_req && wr_lat != 0) begin
            wr_cnt++;
            if (wr_cnt >= wr_lat) begin
                mon_wr_ack = 1'b1;
                mem_rule[mon_wr_addr] = mon_wr_rule;
                mem_mask[mon_wr_addr] = mon_wr_rulemask;
                wr_log.push_back(int'(mon_wr_addr));
                wr_cnt = 0;
            end
        end else begin
            wr_cnt = 0;
        end
        if (mon_rd_req && rd_lat != 0) begin
            rd_cnt++;
            if (rd_cnt >= rd_lat) begin
                mon_rd_ack      = 1'b1;
                mon_rd_rule     = mem_rule[mon_rd_addr] ^
                                  ((int'(mon_rd_addr) == corrupt_addr) ? TW'(1) : TW'(0));
                mon_rd_rulemask = mem_mask[mon_rd_addr];
                rd_cnt = 0;
            end
        end else begin
            rd_cnt = 0;
        end
        if (stray_rd) mon_rd_ack = 1'b1;
        if (stray_wr) mon_wr_ack = 1'b1;
    end

    // Cumulative request-activity counters (cycle ending at each edge).
    int wr_req_cyc = 0;
    int rd_req_cyc = 0;
    int both_cyc   = 0;
    always @(posedge clk) begin
        if (mon_wr_req) wr_req_cyc++;
        if (mon_rd_req) rd_req_cyc++;
        if (mon_wr_req && mon_rd_req) both_cyc++;
    end

    // ---------------- checking helpers ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [DB-1:0] addr,
                            input logic [TW-1:0] rule, input logic [TW-1:0] mask);
        int n;
        n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_addr  = addr;
        bus.cmd_rule  = rule;
        bus.cmd_mask  = mask;
        @(posedge clk);
        while (!bus.cmd_ready && n < 20) begin
            @(posedge clk);
            n++;
        end
        #1;
        bus.cmd_valid = 1'b0;
        chk("cmd_accepted", 128'(n < 20), 128'(1));
    endtask

    // lat = cycle index (relative to the accept edge) in which rsp_valid is first seen
    task automatic wait_rsp(input int max, output int lat);
        lat = 1;
        while (!bus.rsp_valid && lat < max) begin
            tick(1);
            lat++;
        end
        chk("rsp_valid_seen", 128'(bus.rsp_valid), 128'(1));
    endtask

    task automatic take_rsp();
        bus.rsp_ready = 1'b1;
        tick(1);
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int lat, w0, r0, b0, l0, n;
        logic in_order;

        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_addr  = '0;
        bus.cmd_rule  = '0;
        bus.cmd_mask  = '0;
        bus.rsp_ready = 1'b0;
        tick(3);

        // Reset state
        chk("rst_cmd_ready", 128'(bus.cmd_ready), 128'(0));
        chk("rst_rsp_valid", 128'(bus.rsp_valid), 128'(0));
        chk("rst_busy",      128'(busy), 128'(0));
        chk("rst_err_cnt",   128'(err_cnt), 128'(0));
        chk("rst_rd_req",    128'(mon_rd_req), 128'(0));
        chk("rst_wr_req",    128'(mon_wr_req), 128'(0));
        chk("rst_status",    128'(bus.rsp_status), 128'(0));
        chk("rst_wr_addr",   128'(mon_wr_addr), 128'(0));
        reset = 1'b0;
        tick(1);
        chk("ready_after_rst", 128'(bus.cmd_ready), 128'(1));

        // Write addr 5, ack in 3rd request cycle
        w0 = wr_req_cyc; b0 = both_cyc; l0 = wr_log.size();
        send_cmd(2'b01, 4'd5, TW'(104'h0A0B), ONES);
        chk("wr_busy", 128'(busy), 128'(1));
        wait_rsp(20, lat);
        chk("wr_latency",   128'(lat), 128'(WR_LAT_EXP));
        chk("wr_status",    128'(bus.rsp_status), 128'(0));
        chk("wr_rsp_addr",  128'(bus.rsp_addr), 128'(5));
        chk("wr_err_cnt",   128'(err_cnt), 128'(0));
        chk("wr_req_cyc",   128'(wr_req_cyc - w0), 128'(3));
        chk("wr_req_low",   128'(mon_wr_req), 128'(0));
        chk("wr_log_cnt",   128'(wr_log.size() - l0), 128'(1));
        chk("wr_log_addr",  128'(wr_log[wr_log.size()-1]), 128'(5));
        chk("wr_no_overlap",128'(both_cyc - b0), 128'(0));
        chk("wr_mem_rule",  128'(mem_rule[5]), 128'(104'h0A0B));
        tick(2);
        chk("hold_valid",   128'(bus.rsp_valid), 128'(1));
        chk("hold_addr",    128'(bus.rsp_addr), 128'(5));
        chk("hold_no_ready",128'(bus.cmd_ready), 128'(0));
        take_rsp();
        chk("wr_done_valid",128'(bus.rsp_valid), 128'(0));
        chk("wr_done_busy", 128'(busy), 128'(0));

        // Read addr 5 with immediate ack
        r0 = rd_req_cyc;
        send_cmd(2'b00, 4'd5, '0, '0);
        wait_rsp(20, lat);
        chk("rd_latency",  128'(lat), 128'(2));
        chk("rd_status",   128'(bus.rsp_status), 128'(0));
        chk("rd_rsp_addr", 128'(bus.rsp_addr), 128'(5));
        chk("rd_rule",     128'(bus.rsp_rule), 128'(104'h0A0B));
        chk("rd_mask",     128'(bus.rsp_mask), 128'(ONES));
        chk("rd_req_cyc",  128'(rd_req_cyc - r0), 128'(1));
        take_rsp();

        // Fill, ack on second request cycle of each entry
        wr_lat = 2;
        w0 = wr_req_cyc; b0 = both_cyc; l0 = wr_log.size();
        send_cmd(2'b10, 4'hA, TW'(104'h1234_5678), TW'(104'hFF00FF));
        wait_rsp(100, lat);
        chk("fill_latency",  128'(lat), 128'(FILL_LAT_EXP));
        chk("fill_status",   128'(bus.rsp_status), 128'(0));
        chk("fill_rsp_addr", 128'(bus.rsp_addr), 128'(15));
        chk("fill_log_cnt",  128'(wr_log.size() - l0), 128'(16));
        in_order = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if ((l0 + i) >= wr_log.size() || wr_log[l0 + i] != i) in_order = 1'b0;
        end
        chk("fill_order",    128'(in_order), 128'(1));
        chk("fill_wr_cyc",   128'(wr_req_cyc - w0), 128'(32));
        chk("fill_overlap",  128'(both_cyc - b0), 128'(0));
        chk("fill_mem0",     128'(mem_rule[0]), 128'(104'h1234_5678));
        chk("fill_mem15",    128'(mem_mask[15]), 128'(104'hFF00FF));
        take_rsp();

        // Read that never gets an ack
        rd_lat = 0;
        r0 = rd_req_cyc;
        send_cmd(2'b00, 4'd9, '0, '0);
        wait_rsp(100, lat);
        chk("tmo_latency",  128'(lat), 128'(65));
        chk("tmo_rd_cyc",   128'(rd_req_cyc - r0), 128'(64));
        chk("tmo_status",   128'(bus.rsp_status), 128'(1));
        chk("tmo_rsp_addr", 128'(bus.rsp_addr), 128'(9));
        chk("tmo_err_cnt",  128'(err_cnt), 128'(1));
        chk("tmo_req_low",  128'(mon_rd_req), 128'(0));
        // Stray acks while holding the response
        stray_rd = 1'b1; stray_wr = 1'b1;
        tick(1);
        stray_rd = 1'b0; stray_wr = 1'b0;
        tick(1);
        chk("stray_resp_valid",  128'(bus.rsp_valid), 128'(1));
        chk("stray_resp_status", 128'(bus.rsp_status), 128'(1));
        chk("stray_resp_addr",   128'(bus.rsp_addr), 128'(9));
        chk("stray_resp_err",    128'(err_cnt), 128'(1));
        take_rsp();
        // Stray acks while idle
        stray_rd = 1'b1; stray_wr = 1'b1;
        tick(1);
        stray_rd = 1'b0; stray_wr = 1'b0;
        tick(1);
        chk("stray_idle_busy",  128'(busy), 128'(0));
        chk("stray_idle_rd",    128'(mon_rd_req), 128'(0));
        chk("stray_idle_wr",    128'(mon_wr_req), 128'(0));
        chk("stray_idle_valid", 128'(bus.rsp_valid), 128'(0));
        chk("stray_idle_err",   128'(err_cnt), 128'(1));
        chk("stray_idle_ready", 128'(bus.cmd_ready), 128'(1));

        // Reset clears the error count
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("rst2_err_cnt", 128'(err_cnt), 128'(0));
        tick(1);

        // Illegal opcode
        send_cmd(2'b11, 4'd2, '0, '0);
        wait_rsp(20, lat);
        chk("bad_latency",  128'(lat), 128'(1));
        chk("bad_status",   128'(bus.rsp_status), 128'(3));
        chk("bad_rsp_addr", 128'(bus.rsp_addr), 128'(2));
        chk("bad_err_cnt",  128'(err_cnt), 128'(1));
        take_rsp();

        // Reset in the middle of a fill at address 7
        rd_lat = 1;
        send_cmd(2'b10, 4'd0, TW'(104'h55), TW'(104'hAA));
        n = 0;
        while (mon_wr_addr !== 4'd7 && n < 100) begin
            tick(1);
            n++;
        end
        chk("midfill_addr7", 128'(mon_wr_addr), 128'(7));
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("midrst_wr_req",   128'(mon_wr_req), 128'(0));
        chk("midrst_rd_req",   128'(mon_rd_req), 128'(0));
        chk("midrst_busy",     128'(busy), 128'(0));
        chk("midrst_err_cnt",  128'(err_cnt), 128'(0));
        chk("midrst_rsp",      128'(bus.rsp_valid), 128'(0));
        chk("midrst_ready",    128'(bus.cmd_ready), 128'(0));
        tick(1);
        chk("midrst_ready_up", 128'(bus.cmd_ready), 128'(1));
        chk("midrst_busy2",    128'(busy), 128'(0));

`ifdef MON_RULE_READBACK_VERIFY_EN
        // Corrupted readback of entry 3 aborts the fill
        corrupt_addr = 3;
        wr_lat = 2;
        l0 = wr_log.size();
        send_cmd(2'b10, 4'd0, TW'(104'h77), TW'(104'h0F));
        wait_rsp(200, lat);
        chk("vfy_status",   128'(bus.rsp_status), 128'(2));
        chk("vfy_rsp_addr", 128'(bus.rsp_addr), 128'(3));
        chk("vfy_err_cnt",  128'(err_cnt), 128'(1));
        chk("vfy_log_cnt",  128'(wr_log.size() - l0), 128'(4));
        chk("vfy_last_wr",  128'(wr_log[wr_log.size()-1]), 128'(3));
        take_rsp();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
